// File: rtl/ahb_seq_pkg.sv
// Shared state encoding and command-word field layout for the AHB instruction sequencer.
package ahb_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWaitD,
        StIssue,
        StWaitRsp,
        StFinish
    } seq_state_e;

    localparam int unsigned ADDR_LSB  = 16;
    localparam int unsigned RSVD_BIT  = 15;
    localparam int unsigned SIZE_LSB  = 12;
    localparam int unsigned WRITE_BIT = 11;
    localparam int unsigned BURST_LSB = 8;
    localparam int unsigned WDATA_LSB = 0;

    localparam logic [31:0] END_WORD      = 32'h0000_0000;
    localparam logic [2:0]  HBURST_SINGLE = 3'b000;
    localparam logic [2:0]  HSIZE_MAX     = 3'b010;

endpackage

// File: rtl/ahb_instr_sequencer_if.sv
// Command/response channel between the sequencer and the AHB master.
interface ahb_instr_sequencer_if;

    logic        CmdValid;
    logic        CmdReady;
    logic [15:0] CmdAddr;
    logic        CmdWrite;
    logic [2:0]  CmdSize;
    logic [2:0]  CmdBurst;
    logic [7:0]  CmdWData;
    logic        RspValid;
    logic [7:0]  RspData;

    modport master (
        output CmdValid, CmdAddr, CmdWrite, CmdSize, CmdBurst, CmdWData,
        input  CmdReady, RspValid, RspData
    );

    modport slave (
        input  CmdValid, CmdAddr, CmdWrite, CmdSize, CmdBurst, CmdWData,
        output CmdReady, RspValid, RspData
    );

endinterface

// File: rtl/ahb_cmd_decode.sv
// Splits a 32-bit command word into AHB transfer fields and flags END / illegal words.
module ahb_cmd_decode
    import ahb_seq_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [15:0] addr_o,
    output logic [2:0]  size_o,
    output logic        write_o,
    output logic [2:0]  burst_o,
    output logic [7:0]  wdata_o,
    output logic        is_end_o,
    output logic        is_illegal_o
);

    assign addr_o  = word_i[ADDR_LSB +: 16];
    assign size_o  = word_i[SIZE_LSB +: 3];
    assign write_o = word_i[WRITE_BIT];
    assign burst_o = word_i[BURST_LSB +: 3];
    assign wdata_o = word_i[WDATA_LSB +: 8];

    assign is_end_o     = (word_i == END_WORD);
    assign is_illegal_o = word_i[RSVD_BIT] || (burst_o != HBURST_SINGLE) || (size_o > HSIZE_MAX);

endmodule

// File: rtl/ahb_instr_sequencer.sv
// Fetches command words from the instruction store, issues them as single AHB transfers
// and captures read data; runs from START_PC until END, an illegal word, the last slot or Abort.
module ahb_instr_sequencer
    import ahb_seq_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter int unsigned START_PC = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  Start,
    input  logic                  Abort,
    output logic [ADDR_W-1:0]     InstrAddr,
    output logic                  InstrRdEn,
    input  logic [WIDTH-1:0]      InstrData,
    ahb_instr_sequencer_if.master cmd,
    output logic [7:0]            RdData,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error,
    output logic [ADDR_W:0]       CmdCount
);

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CNT_MAX = (ADDR_W + 1)'(DEPTH);

    seq_state_e        state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              rd_en_q;
    logic              cmd_valid_q;
    logic [15:0]       cmd_addr_q;
    logic              cmd_write_q;
    logic [2:0]        cmd_size_q;
    logic [2:0]        cmd_burst_q;
    logic [7:0]        cmd_wdata_q;
    logic [7:0]        rd_data_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic [ADDR_W:0]   cmd_count_q;
    logic              abort_pend_q;

    logic [15:0] dec_addr;
    logic [2:0]  dec_size;
    logic        dec_write;
    logic [2:0]  dec_burst;
    logic [7:0]  dec_wdata;
    logic        dec_is_end;
    logic        dec_is_illegal;

    ahb_cmd_decode u_decode (
        .word_i       (InstrData),
        .addr_o       (dec_addr),
        .size_o       (dec_size),
        .write_o      (dec_write),
        .burst_o      (dec_burst),
        .wdata_o      (dec_wdata),
        .is_end_o     (dec_is_end),
        .is_illegal_o (dec_is_illegal)
    );

    // An Abort seen at any point of the run is remembered until the next safe stop.
    logic abort_any;
    logic advance;

    assign abort_any = Abort || abort_pend_q;
    assign advance   = ((state_q == StIssue) && cmd.CmdReady && cmd_write_q) ||
                       ((state_q == StWaitRsp) && cmd.RspValid);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q      <= StIdle;
            pc_q         <= '0;
            rd_en_q      <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_write_q  <= 1'b0;
            cmd_size_q   <= '0;
            cmd_burst_q  <= '0;
            cmd_wdata_q  <= '0;
            rd_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cmd_count_q  <= '0;
            abort_pend_q <= 1'b0;
        end else begin
            if ((state_q != StIdle) && Abort) abort_pend_q <= 1'b1;

            unique case (state_q)
                StIdle: begin
                    if (Start && !Abort) begin
                        pc_q         <= ADDR_W'(START_PC);
                        cmd_count_q  <= '0;
                        error_q      <= 1'b0;
                        abort_pend_q <= 1'b0;
                        rd_en_q      <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= StFetch;
                    end
                end
                StFetch: begin
                    rd_en_q <= 1'b0;
                    state_q <= abort_any ? StFinish : StWaitD;
                end
                StWaitD: begin
                    if (abort_any || dec_is_end) begin
                        done_q  <= !abort_any;
                        state_q <= StFinish;
                    end else if (dec_is_illegal) begin
                        error_q <= 1'b1;
                        state_q <= StFinish;
                    end else begin
                        cmd_addr_q  <= dec_addr;
                        cmd_write_q <= dec_write;
                        cmd_size_q  <= dec_size;
                        cmd_burst_q <= dec_burst;
                        cmd_wdata_q <= dec_wdata;
                        cmd_valid_q <= 1'b1;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    if (cmd.CmdReady) begin
                        cmd_valid_q <= 1'b0;
                        if (cmd_count_q != CNT_MAX) cmd_count_q <= cmd_count_q + 1'b1;
                        if (!cmd_write_q) state_q <= StWaitRsp;
                    end
                end
                StWaitRsp: begin
                    if (cmd.RspValid) rd_data_q <= cmd.RspData;
                end
                StFinish: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase

            // Completed write handshake or read response: step to the next slot, never wrapping.
            if (advance) begin
                if (abort_any || (pc_q == LAST_PC)) begin
                    done_q  <= !abort_any && !error_q;
                    state_q <= StFinish;
                end else begin
                    pc_q    <= pc_q + 1'b1;
                    rd_en_q <= 1'b1;
                    state_q <= StFetch;
                end
            end
        end
    end

    assign InstrAddr    = pc_q;
    assign InstrRdEn    = rd_en_q;
    assign cmd.CmdValid = cmd_valid_q;
    assign cmd.CmdAddr  = cmd_addr_q;
    assign cmd.CmdWrite = cmd_write_q;
    assign cmd.CmdSize  = cmd_size_q;
    assign cmd.CmdBurst = cmd_burst_q;
    assign cmd.CmdWData = cmd_wdata_q;
    assign RdData       = rd_data_q;
    assign Busy         = busy_q;
    assign Done         = done_q;
    assign Error        = error_q;
    assign CmdCount     = cmd_count_q;

endmodule

// File: tb/tb_ahb_instr_sequencer.sv
// Directed and randomized programs run against a program-level reference model.
module tb_ahb_instr_sequencer;

    localparam int DEPTH = 32;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        Start;
    logic        Abort;
    logic [4:0]  InstrAddr;
    logic        InstrRdEn;
    logic [31:0] InstrData;
    logic [7:0]  RdData;
    logic        Busy;
    logic        Done;
    logic        Error;
    logic [5:0]  CmdCount;

    ahb_instr_sequencer_if cmd_bus ();

    ahb_instr_sequencer dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .Start     (Start),
        .Abort     (Abort),
        .InstrAddr (InstrAddr),
        .InstrRdEn (InstrRdEn),
        .InstrData (InstrData),
        .cmd       (cmd_bus),
        .RdData    (RdData),
        .Busy      (Busy),
        .Done      (Done),
        .Error     (Error),
        .CmdCount  (CmdCount)
    );

    always #5 HCLK = ~HCLK;

    logic [31:0] mem [DEPTH];

    always @(posedge HCLK) begin
        if (InstrRdEn) InstrData <= mem[InstrAddr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] hs_q [$];
    int          hs_cyc_q [$];
    int          done_cnt;
    int          first_valid_cyc;
    int          busy_fall_cyc;
    int          stall_checks;
    int          fetch_cyc [DEPTH];
    logic [7:0]  exp_rd;
    bit          use_fixed_rsp;
    logic [7:0]  fixed_rsp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] rand_word(input bit illegal);
        logic [31:0] w;
        w = {16'($urandom), 1'b0, 3'($urandom_range(2)), 1'($urandom_range(1)), 3'b000,
             8'($urandom)};
        if (w == 32'h0) w[0] = 1'b1;
        if (illegal) begin
            case ($urandom_range(2))
                0:       w[15] = 1'b1;
                1:       w[10:8] = 3'($urandom_range(7, 1));
                default: w[14:12] = 3'($urandom_range(7, 3));
            endcase
        end
        return w;
    endfunction

    // Starts a program and plays instruction store / AHB master until Busy falls.
    task automatic run_prog(input int rdy_pct, input int stall_first, input bit abort_issue,
                            input bit start_busy, input int max_cyc);
        int         stall_left;
        bit         prev_stall;
        logic [15:0] prev_addr;
        bit         rsp_pend;
        int         rsp_wait;
        bit         rdy;
        int         c;
        hs_q.delete();
        hs_cyc_q.delete();
        done_cnt        = 0;
        first_valid_cyc = -1;
        busy_fall_cyc   = -1;
        stall_checks    = 0;
        foreach (fetch_cyc[i]) fetch_cyc[i] = -1;
        stall_left = stall_first;
        prev_stall = 1'b0;
        prev_addr  = '0;
        rsp_pend   = 1'b0;
        rsp_wait   = 0;
        Start = 1'b1;
        @(negedge HCLK);
        Start = 1'b0;
        for (c = 1; c < max_cyc; c++) begin
            if (Done) done_cnt++;
            if (InstrRdEn) fetch_cyc[InstrAddr] = c;
            if (prev_stall) begin
                stall_checks++;
                check("stall_valid", cmd_bus.CmdValid, 1);
                check("stall_addr", cmd_bus.CmdAddr, prev_addr);
            end
            if (!Busy) begin
                busy_fall_cyc = c;
                break;
            end
            Start = start_busy && (c == 4);
            cmd_bus.RspValid = 1'b0;
            if (rsp_pend) begin
                if (rsp_wait == 0) begin
                    cmd_bus.RspValid = 1'b1;
                    cmd_bus.RspData  = use_fixed_rsp ? fixed_rsp : 8'($urandom);
                    exp_rd           = cmd_bus.RspData;
                    rsp_pend         = 1'b0;
                end else begin
                    rsp_wait--;
                end
            end
            rdy = 1'b0;
            if (cmd_bus.CmdValid) begin
                if (first_valid_cyc < 0) first_valid_cyc = c;
                if (abort_issue) Abort = 1'b1;
                if (stall_left > 0) stall_left--;
                else rdy = ($urandom_range(99) < rdy_pct);
            end
            cmd_bus.CmdReady = rdy;
            prev_stall = cmd_bus.CmdValid && !rdy;
            prev_addr  = cmd_bus.CmdAddr;
            if (cmd_bus.CmdValid && rdy) begin
                hs_q.push_back({cmd_bus.CmdAddr, 1'b0, cmd_bus.CmdSize, cmd_bus.CmdWrite,
                                cmd_bus.CmdBurst, cmd_bus.CmdWData});
                hs_cyc_q.push_back(c);
                if (!cmd_bus.CmdWrite) begin
                    rsp_pend = 1'b1;
                    rsp_wait = $urandom_range(3);
                end
            end
            @(negedge HCLK);
        end
        check("run_timeout", (c < max_cyc), 1);
        Start            = 1'b0;
        Abort            = 1'b0;
        cmd_bus.CmdReady = 1'b0;
        cmd_bus.RspValid = 1'b0;
    endtask

    // Walks the program by the encoding rules and compares the observed run with it.
    task automatic check_run(input string name, input int abort_after);
        logic [31:0] exp_q [$];
        bit          exp_done;
        bit          exp_err;
        logic [31:0] w;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        for (int pc = 0; pc < DEPTH; pc++) begin
            w = mem[pc];
            if (w == 32'h0) begin
                exp_done = 1'b1;
                break;
            end
            if (w[15] || (w[10:8] != 3'b000) || (w[14:12] > 3'd2)) begin
                exp_err = 1'b1;
                break;
            end
            exp_q.push_back(w);
            if ((abort_after >= 0) && (exp_q.size() == abort_after)) break;
            if (pc == DEPTH - 1) exp_done = 1'b1;
        end
        check({name, "_ncmd"}, hs_q.size(), exp_q.size());
        for (int i = 0; (i < hs_q.size()) && (i < exp_q.size()); i++) begin
            w = exp_q[i];
            check({name, "_addr"}, hs_q[i][31:16], w[31:16]);
            check({name, "_write"}, hs_q[i][11], w[11]);
            check({name, "_size"}, hs_q[i][14:12], w[14:12]);
            check({name, "_burst"}, hs_q[i][10:8], 0);
            if (w[11]) check({name, "_wdata"}, hs_q[i][7:0], w[7:0]);
        end
        check({name, "_done"}, done_cnt, exp_done);
        check({name, "_error"}, Error, exp_err);
        check({name, "_count"}, CmdCount, exp_q.size());
        check({name, "_rddata"}, RdData, exp_rd);
        check({name, "_idle"}, Busy, 0);
    endtask

    initial begin
        bit hit;
        HRESET           = 1'b1;
        Start            = 1'b0;
        Abort            = 1'b0;
        cmd_bus.CmdReady = 1'b0;
        cmd_bus.RspValid = 1'b0;
        cmd_bus.RspData  = '0;
        use_fixed_rsp    = 1'b0;
        fixed_rsp        = '0;
        exp_rd           = '0;
        foreach (mem[i]) mem[i] = '0;
        repeat (3) @(negedge HCLK);

        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_error", Error, 0);
        check("rst_count", CmdCount, 0);
        check("rst_rddata", RdData, 0);
        check("rst_cmdvalid", cmd_bus.CmdValid, 0);
        check("rst_rden", InstrRdEn, 0);
        check("rst_addr", InstrAddr, 0);
        HRESET = 1'b0;
        @(negedge HCLK);

        // Write then read then END.
        mem[0] = 32'h0001_28AA;
        mem[1] = 32'h0002_2000;
        mem[2] = 32'h0000_0000;
        use_fixed_rsp = 1'b1;
        fixed_rsp     = 8'h5C;
        run_prog(100, 0, 1'b0, 1'b0, 200);
        check_run("t1", -1);
        check("t1_latency", first_valid_cyc, 3);
        check("t1_rddata_5c", RdData, 8'h5C);
        check("t1_count2", CmdCount, 2);
        use_fixed_rsp = 1'b0;

        // Five-cycle stall in ISSUE.
        mem[0] = 32'h0010_1855;
        mem[1] = 32'h0000_0000;
        run_prog(100, 5, 1'b0, 1'b0, 200);
        check_run("t2", -1);
        check("t2_stall_cycles", stall_checks, 5);

        // Reserved bit set in slot 1.
        mem[0] = 32'h0020_0812;
        mem[1] = 32'h0003_8000;
        run_prog(100, 0, 1'b0, 1'b0, 200);
        check_run("t3", -1);
        check("t3_busy_fall", busy_fall_cyc - (fetch_cyc[1] + 1), 2);

        // Every slot a write: last slot stops the run.
        for (int i = 0; i < DEPTH; i++) mem[i] = {16'(i + 256), 16'h1800 | 16'(i)};
        run_prog(100, 0, 1'b0, 1'b0, 400);
        check_run("t4", -1);
        check("t4_spacing", (hs_cyc_q.size() == DEPTH) ? hs_cyc_q[DEPTH-1] - hs_cyc_q[0] : -1, 93);
        check("t4_no_wrap", fetch_cyc[0], 1);

        // Abort during a stalled ISSUE, with a Start pulse while busy.
        for (int i = 0; i < 4; i++) mem[i] = {16'(i + 16'h40), 16'h0830 | 16'(i)};
        mem[4] = 32'h0000_0000;
        run_prog(100, 3, 1'b1, 1'b1, 200);
        check_run("t5", 1);
        repeat (2) @(negedge HCLK);
        check("t5_stays_idle", Busy, 0);
        check("t5_count_held", CmdCount, 1);

        // Reset while waiting for a read response.
        mem[0] = 32'h0004_2000;
        mem[1] = 32'h0000_0000;
        check("t6_pre_rddata", RdData, 8'h5C);
        Start = 1'b1;
        @(negedge HCLK);
        Start = 1'b0;
        cmd_bus.CmdReady = 1'b1;
        hit = 1'b0;
        for (int c = 0; (c < 20) && !hit; c++) begin
            hit = cmd_bus.CmdValid;
            @(negedge HCLK);
        end
        check("t6_reached_issue", hit, 1);
        check("t6_pre_busy", Busy, 1);
        check("t6_pre_count", CmdCount, 1);
        cmd_bus.CmdReady = 1'b0;
        HRESET = 1'b1;
        @(negedge HCLK);
        check("t6_cmdvalid", cmd_bus.CmdValid, 0);
        check("t6_busy", Busy, 0);
        check("t6_rddata", RdData, 0);
        check("t6_count", CmdCount, 0);
        HRESET = 1'b0;
        exp_rd = '0;
        @(negedge HCLK);

        // Start and Abort together while idle.
        mem[0] = 32'h0050_0801;
        Start = 1'b1;
        Abort = 1'b1;
        @(negedge HCLK);
        Start = 1'b0;
        Abort = 1'b0;
        check("sa_busy", Busy, 0);
        check("sa_rden", InstrRdEn, 0);
        @(negedge HCLK);
        check("sa_busy_later", Busy, 0);

        for (int r = 0; r < 8; r++) begin
            int len;
            len = $urandom_range(32, 1);
            for (int i = 0; i < DEPTH; i++)
                mem[i] = (i < len) ? rand_word($urandom_range(19) == 0) : 32'h0;
            run_prog($urandom_range(100, 40), 0, 1'b0, 1'b0, 3000);
            check_run("rand", -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
